// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types.
//   word_t          : 32-bit machine word
//   regbits_t       : register-file select field
//   mem_op_t        : memory operation carried by an instruction
//   WORD_ALIGN_MASK : clears the byte offset within a word
package cpu_types_pkg;

  typedef logic [31:0] word_t;
  typedef logic [4:0]  regbits_t;

  typedef enum logic [2:0] {
    MEM_NONE = 3'd0,
    MEM_LW   = 3'd1,
    MEM_SW   = 3'd2,
    MEM_LL   = 3'd3,
    MEM_SC   = 3'd4
  } mem_op_t;

  localparam word_t WORD_ALIGN_MASK = 32'hFFFF_FFFC;

endpackage

// File: rtl/llsc_link.sv
// LL/SC link register: remembers the word most recently load-linked and
// whether that reservation is still intact.
//   CLK, RST     : clock, asynchronous active-high reset
//   set/set_addr : LL completes, reserve set_addr
//   clear        : drop the reservation (SC, SW to the linked word, failed SC)
//   snoop_inval/snoop_addr : another agent wrote a line
//   query_addr   : address an SC (or SW) is asking about
//   sc_ok        : reservation valid and query_addr is in the linked word
module llsc_link
  import cpu_types_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              set,
  input  logic [ADDR_W-1:0] set_addr,
  input  logic              clear,
  input  logic              snoop_inval,
  input  logic [ADDR_W-1:0] snoop_addr,
  input  logic [ADDR_W-1:0] query_addr,
  output logic              sc_ok
);

  localparam logic [ADDR_W-1:0] MASK = WORD_ALIGN_MASK[ADDR_W-1:0];

  logic              link_valid;
  logic [ADDR_W-1:0] link_addr;
  logic [ADDR_W-1:0] snoop_ref;
  logic              snoop_hit;

  // While an LL is landing, the snoop is compared with the word being
  // reserved, so a coincident remote write to it leaves the link invalid.
  assign snoop_ref = set ? set_addr : link_addr;
  assign snoop_hit = snoop_inval && ((snoop_addr & MASK) == (snoop_ref & MASK));
  assign sc_ok     = link_valid && ((query_addr & MASK) == (link_addr & MASK));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      link_valid <= 1'b0;
      link_addr  <= '0;
    end else if (set) begin
      link_addr  <= set_addr;
      link_valid <= ~snoop_hit;
    end else if (clear || snoop_hit) begin
      link_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage following the ALU. Takes one executed instruction per
// handshake, raises overflow/misalignment exceptions, issues word requests to
// the data cache and holds them until dhit, maintains the LL/SC link and
// emits a one-cycle writeback packet.
//   CLK, RST                     : clock, asynchronous active-high reset
//   ex_*                         : instruction from the ALU stage (valid/ready)
//   flush                        : squash the instruction offered this cycle
//   dmemREN/WEN/addr/store       : registered cache request, held until dhit
//   dhit, dmemload               : cache completion and read data
//   snoop_inval, snoop_addr      : remote write notification
//   wb_*                         : writeback packet (wb_valid is a pulse)
module mem_stage
  import cpu_types_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic              flush,
  input  logic [ADDR_W-1:0] ex_aluout,
  input  logic              ex_overflow,
  input  logic              ex_ovf_trap,
  input  mem_op_t           ex_memop,
  input  logic [ADDR_W-1:0] ex_store,
  input  logic [REG_W-1:0]  ex_wsel,
  input  logic              ex_regwen,
  output logic              dmemREN,
  output logic              dmemWEN,
  output logic [ADDR_W-1:0] dmemaddr,
  output logic [ADDR_W-1:0] dmemstore,
  input  logic              dhit,
  input  logic [ADDR_W-1:0] dmemload,
  input  logic              snoop_inval,
  input  logic [ADDR_W-1:0] snoop_addr,
  output logic              wb_valid,
  output logic [ADDR_W-1:0] wb_result,
  output logic [REG_W-1:0]  wb_wsel,
  output logic              wb_regwen,
  output logic              wb_exception
);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t            state;
  mem_op_t           op_p1;
  logic [REG_W-1:0]  wsel_p1;
  logic              regwen_p1;

  logic              accept_p0;
  logic              except_p0;
  logic              sc_fail_p0;
  logic              done_p1;
  logic              sc_ok;
  logic              link_set;
  logic              link_clear;
  logic [ADDR_W-1:0] query_addr;

  assign accept_p0  = ex_valid && ex_ready && !flush;
  assign except_p0  = (ex_ovf_trap && ex_overflow) ||
                      ((ex_memop != MEM_NONE) && (ex_aluout[1:0] != 2'b00));
  assign sc_fail_p0 = accept_p0 && !except_p0 && (ex_memop == MEM_SC) && !sc_ok;
  assign done_p1    = (state == ACCESS) && dhit;

  // In IDLE the link is asked about the offered SC; during an access it is
  // asked about the outstanding address so an SW can detect a linked word.
  assign query_addr = (state == ACCESS) ? dmemaddr : ex_aluout;
  assign link_set   = done_p1 && (op_p1 == MEM_LL);
  assign link_clear = sc_fail_p0 ||
                      (done_p1 && ((op_p1 == MEM_SC) || ((op_p1 == MEM_SW) && sc_ok)));

  llsc_link #(.ADDR_W(ADDR_W)) u_link (
    .CLK         (CLK),
    .RST         (RST),
    .set         (link_set),
    .set_addr    (dmemaddr),
    .clear       (link_clear),
    .snoop_inval (snoop_inval),
    .snoop_addr  (snoop_addr),
    .query_addr  (query_addr),
    .sc_ok       (sc_ok)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state        <= IDLE;
      ex_ready     <= 1'b1;
      dmemREN      <= 1'b0;
      dmemWEN      <= 1'b0;
      dmemaddr     <= '0;
      dmemstore    <= '0;
      wb_valid     <= 1'b0;
      wb_result    <= '0;
      wb_wsel      <= '0;
      wb_regwen    <= 1'b0;
      wb_exception <= 1'b0;
      op_p1        <= MEM_NONE;
      wsel_p1      <= '0;
      regwen_p1    <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      case (state)
        // p0 -> p1: classify the accepted instruction
        IDLE: begin
          if (accept_p0) begin
            if (except_p0) begin
              wb_valid     <= 1'b1;
              wb_exception <= 1'b1;
              wb_regwen    <= 1'b0;
              wb_result    <= ex_aluout;
              wb_wsel      <= ex_wsel;
            end else if (ex_memop == MEM_NONE) begin
              wb_valid     <= 1'b1;
              wb_exception <= 1'b0;
              wb_regwen    <= ex_regwen;
              wb_result    <= ex_aluout;
              wb_wsel      <= ex_wsel;
            end else if (sc_fail_p0) begin
              wb_valid     <= 1'b1;
              wb_exception <= 1'b0;
              wb_regwen    <= ex_regwen;
              wb_result    <= '0;
              wb_wsel      <= ex_wsel;
            end else begin
              state     <= ACCESS;
              ex_ready  <= 1'b0;
              dmemaddr  <= ex_aluout;
              dmemREN   <= (ex_memop == MEM_LW) || (ex_memop == MEM_LL);
              dmemWEN   <= (ex_memop == MEM_SW) || (ex_memop == MEM_SC);
              if ((ex_memop == MEM_SW) || (ex_memop == MEM_SC))
                dmemstore <= ex_store;
              op_p1     <= ex_memop;
              wsel_p1   <= ex_wsel;
              regwen_p1 <= ex_regwen;
            end
          end
        end
        // p1 -> p2: request held until the cache answers
        ACCESS: begin
          if (dhit) begin
            state        <= IDLE;
            ex_ready     <= 1'b1;
            dmemREN      <= 1'b0;
            dmemWEN      <= 1'b0;
            wb_valid     <= 1'b1;
            wb_exception <= 1'b0;
            wb_wsel      <= wsel_p1;
            wb_regwen    <= regwen_p1 && (op_p1 != MEM_SW);
            case (op_p1)
              MEM_LW, MEM_LL: wb_result <= dmemload;
              MEM_SC:         wb_result <= ADDR_W'(1);
              default:        wb_result <= '0;
            endcase
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: reset/hand-written sequences, a vector table and a
// randomized run against a word-level reference model of the LL/SC rules.
module tb_mem_stage;
  import cpu_types_pkg::*;

  logic        CLK = 1'b0;
  logic        RST;
  logic        ex_valid, ex_ready, flush;
  word_t       ex_aluout, ex_store;
  logic        ex_overflow, ex_ovf_trap;
  mem_op_t     ex_memop;
  logic [4:0]  ex_wsel;
  logic        ex_regwen;
  logic        dmemREN, dmemWEN;
  word_t       dmemaddr, dmemstore;
  logic        dhit;
  word_t       dmemload;
  logic        snoop_inval;
  word_t       snoop_addr;
  logic        wb_valid;
  word_t       wb_result;
  logic [4:0]  wb_wsel;
  logic        wb_regwen, wb_exception;

  mem_stage #(.ADDR_W(32), .REG_W(5)) dut (
    .CLK(CLK), .RST(RST), .ex_valid(ex_valid), .ex_ready(ex_ready), .flush(flush),
    .ex_aluout(ex_aluout), .ex_overflow(ex_overflow), .ex_ovf_trap(ex_ovf_trap),
    .ex_memop(ex_memop), .ex_store(ex_store), .ex_wsel(ex_wsel), .ex_regwen(ex_regwen),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
    .dhit(dhit), .dmemload(dmemload), .snoop_inval(snoop_inval), .snoop_addr(snoop_addr),
    .wb_valid(wb_valid), .wb_result(wb_result), .wb_wsel(wb_wsel),
    .wb_regwen(wb_regwen), .wb_exception(wb_exception)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    mem_op_t op; word_t addr; word_t st; logic [4:0] ws; logic rw; logic trap; logic ovf;
    int lat; word_t load; logic [1:0] ereq; word_t eres; logic erw; logic eexc;
  } vec_t;

  typedef struct {
    logic [1:0] req; word_t raddr; word_t rstore; int held; logic busy_rdy;
    logic dropped; logic wbv; word_t res; logic [4:0] ws; logic rw; logic exc;
  } obs_t;

  int    n_pass = 0;
  int    n_total = 0;
  logic  m_valid;
  word_t m_addr;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
  endtask

  function automatic vec_t mk(mem_op_t op, word_t a, word_t st, logic [4:0] ws, logic rw,
                              logic trap, logic ovf, int lat, word_t load,
                              logic [1:0] ereq, word_t eres, logic erw, logic eexc);
    vec_t v;
    v.op = op; v.addr = a; v.st = st; v.ws = ws; v.rw = rw; v.trap = trap; v.ovf = ovf;
    v.lat = lat; v.load = load; v.ereq = ereq; v.eres = eres; v.erw = erw; v.eexc = eexc;
    return v;
  endfunction

  // Offers one instruction, serves any request after lat wait cycles and
  // captures what the stage did. Called #1 after a rising edge.
  task automatic run_instr(input mem_op_t op, input word_t a, input word_t st,
                           input logic [4:0] ws, input logic rw, input logic trap,
                           input logic ovf, input int lat, input word_t load,
                           input logic snp, input word_t snp_a, output obs_t o);
    o = '{default: 0};
    ex_valid = 1'b1; ex_memop = op; ex_aluout = a; ex_store = st; ex_wsel = ws;
    ex_regwen = rw; ex_ovf_trap = trap; ex_overflow = ovf;
    @(posedge CLK); #1;
    ex_valid = 1'b0; ex_memop = MEM_NONE; ex_ovf_trap = 1'b0; ex_overflow = 1'b0;
    o.req = {dmemWEN, dmemREN};
    if (dmemREN || dmemWEN) begin
      o.raddr = dmemaddr; o.rstore = dmemstore; o.busy_rdy = ex_ready;
      for (int i = 0; i <= lat; i++) begin
        if (i == lat) begin
          dhit = 1'b1; dmemload = load;
          if (snp) begin snoop_inval = 1'b1; snoop_addr = snp_a; end
        end
        if ({dmemWEN, dmemREN} == o.req && dmemaddr == o.raddr) o.held++;
        @(posedge CLK); #1;
      end
      dhit = 1'b0; snoop_inval = 1'b0;
      o.dropped = !(dmemREN || dmemWEN);
    end
    o.wbv = wb_valid; o.res = wb_result; o.ws = wb_wsel; o.rw = wb_regwen; o.exc = wb_exception;
  endtask

  task automatic compare(input string t, input logic [1:0] ereq, input word_t ea, input word_t est,
                         input int lat, input word_t eres, input logic [4:0] ews,
                         input logic erw, input logic eexc, input obs_t o);
    chk({t, ".req"}, o.req, ereq);
    if (ereq != 2'd0) begin
      chk({t, ".addr"}, o.raddr, ea);
      if (ereq == 2'd2) chk({t, ".store"}, o.rstore, est);
      chk({t, ".held"}, o.held, lat + 1);
      chk({t, ".busy_ready"}, o.busy_rdy, 1'b0);
      chk({t, ".drop"}, o.dropped, 1'b1);
    end
    chk({t, ".wb_valid"}, o.wbv, 1'b1);
    chk({t, ".exc"}, o.exc, eexc);
    chk({t, ".regwen"}, o.rw, erw);
    if (!eexc) begin
      chk({t, ".result"}, o.res, eres);
      chk({t, ".wsel"}, o.ws, ews);
    end
  endtask

  // Reference model: applies the stage's rules to one instruction at word
  // granularity and updates the modelled reservation.
  task automatic model(input mem_op_t op, input word_t a, input logic rw, input logic trap,
                       input logic ovf, input word_t load, output logic [1:0] req,
                       output word_t res, output logic erw, output logic exc);
    req = 2'd0; res = '0; erw = 1'b0; exc = 1'b0;
    if (trap && ovf) exc = 1'b1;
    else if (op != MEM_NONE && (a % 4) != 0) exc = 1'b1;
    else if (op == MEM_NONE) begin res = a; erw = rw; end
    else if (op == MEM_SC && !(m_valid && (a / 4) == (m_addr / 4))) begin
      res = '0; erw = rw; m_valid = 1'b0;
    end else begin
      case (op)
        MEM_LW: begin req = 2'd1; res = load; erw = rw; end
        MEM_LL: begin req = 2'd1; res = load; erw = rw; m_valid = 1'b1; m_addr = a; end
        MEM_SW: begin
          req = 2'd2; res = '0; erw = 1'b0;
          if (m_valid && (a / 4) == (m_addr / 4)) m_valid = 1'b0;
        end
        default: begin req = 2'd2; res = 32'd1; erw = rw; m_valid = 1'b0; end
      endcase
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    obs_t       o;
    vec_t       tbl[16];
    logic       seen;
    logic [1:0] ereq;
    word_t      eres, a, sa, st, ld;
    logic       erw, eexc, trap, ovf, rw;
    mem_op_t    op;
    int         lat;
    logic [4:0] ws;

    RST = 1'b1; ex_valid = 1'b0; flush = 1'b0; ex_aluout = '0; ex_store = '0;
    ex_overflow = 1'b0; ex_ovf_trap = 1'b0; ex_memop = MEM_NONE; ex_wsel = '0;
    ex_regwen = 1'b0; dhit = 1'b0; dmemload = '0; snoop_inval = 1'b0; snoop_addr = '0;
    #2;
    chk("rst.ex_ready", ex_ready, 1'b1);
    chk("rst.dmemREN", dmemREN, 1'b0);
    chk("rst.dmemWEN", dmemWEN, 1'b0);
    chk("rst.dmemaddr", dmemaddr, 32'h0);
    chk("rst.wb_valid", wb_valid, 1'b0);
    chk("rst.wb_result", wb_result, 32'h0);
    chk("rst.wb_exception", wb_exception, 1'b0);
    @(posedge CLK); @(posedge CLK); #1;
    RST = 1'b0;

    // Back-to-back non-memory instructions at full throughput
    ex_valid = 1'b1; ex_memop = MEM_NONE; ex_aluout = 32'h5; ex_wsel = 5'd3; ex_regwen = 1'b1;
    @(posedge CLK); #1;
    chk("b2b.ready", ex_ready, 1'b1);
    ex_aluout = 32'h9;
    chk("b2b.wbv0", wb_valid, 1'b1);
    chk("b2b.res0", wb_result, 32'h5);
    @(posedge CLK); #1;
    ex_valid = 1'b0;
    chk("b2b.wbv1", wb_valid, 1'b1);
    chk("b2b.res1", wb_result, 32'h9);
    chk("b2b.wsel1", wb_wsel, 5'd3);
    @(posedge CLK); #1;
    chk("b2b.wbv_end", wb_valid, 1'b0);

    // Vector table, link state carried from entry to entry
    tbl[0]  = mk(MEM_NONE, 32'h5,        32'h0,    5'd3,  1, 0, 0, 0, 32'h0,        2'd0, 32'h5,        1, 0);
    tbl[1]  = mk(MEM_LW,   32'h100,      32'h0,    5'd4,  1, 0, 0, 3, 32'hDEADBEEF, 2'd1, 32'hDEADBEEF, 1, 0);
    tbl[2]  = mk(MEM_NONE, 32'h80000000, 32'h0,    5'd5,  1, 1, 1, 0, 32'h0,        2'd0, 32'h0,        0, 1);
    tbl[3]  = mk(MEM_SW,   32'h102,      32'h11,   5'd6,  0, 1, 1, 0, 32'h0,        2'd0, 32'h0,        0, 1);
    tbl[4]  = mk(MEM_SW,   32'h102,      32'h11,   5'd6,  0, 0, 0, 0, 32'h0,        2'd0, 32'h0,        0, 1);
    tbl[5]  = mk(MEM_LL,   32'h200,      32'h0,    5'd7,  1, 0, 0, 0, 32'h55,       2'd1, 32'h55,       1, 0);
    tbl[6]  = mk(MEM_SC,   32'h200,      32'h7,    5'd8,  1, 0, 0, 1, 32'h0,        2'd2, 32'h1,        1, 0);
    tbl[7]  = mk(MEM_SC,   32'h200,      32'h7,    5'd8,  1, 0, 0, 0, 32'h0,        2'd0, 32'h0,        1, 0);
    tbl[8]  = mk(MEM_SW,   32'h40,       32'h1234, 5'd9,  1, 0, 0, 2, 32'h0,        2'd2, 32'h0,        0, 0);
    tbl[9]  = mk(MEM_NONE, 32'h7,        32'h0,    5'd10, 1, 1, 0, 0, 32'h0,        2'd0, 32'h7,        1, 0);
    tbl[10] = mk(MEM_LL,   32'h300,      32'h0,    5'd11, 1, 0, 0, 0, 32'h99,       2'd1, 32'h99,       1, 0);
    tbl[11] = mk(MEM_SW,   32'h300,      32'h3,    5'd12, 1, 0, 0, 0, 32'h0,        2'd2, 32'h0,        0, 0);
    tbl[12] = mk(MEM_SC,   32'h300,      32'h4,    5'd13, 1, 0, 0, 0, 32'h0,        2'd0, 32'h0,        1, 0);
    tbl[13] = mk(MEM_LL,   32'h400,      32'h0,    5'd14, 0, 0, 0, 1, 32'hA,        2'd1, 32'hA,        0, 0);
    tbl[14] = mk(MEM_SC,   32'h404,      32'h5,    5'd15, 1, 0, 0, 0, 32'h0,        2'd0, 32'h0,        1, 0);
    tbl[15] = mk(MEM_SC,   32'h400,      32'h5,    5'd16, 1, 0, 0, 0, 32'h0,        2'd0, 32'h0,        1, 0);
    for (int i = 0; i < 16; i++) begin
      run_instr(tbl[i].op, tbl[i].addr, tbl[i].st, tbl[i].ws, tbl[i].rw, tbl[i].trap,
                tbl[i].ovf, tbl[i].lat, tbl[i].load, 1'b0, 32'h0, o);
      compare($sformatf("vec%0d", i), tbl[i].ereq, tbl[i].addr, tbl[i].st, tbl[i].lat,
              tbl[i].eres, tbl[i].ws, tbl[i].erw, tbl[i].eexc, o);
    end

    // Flush squashes the offered instruction
    ex_valid = 1'b1; flush = 1'b1; ex_memop = MEM_LW; ex_aluout = 32'h100;
    @(posedge CLK); #1;
    ex_valid = 1'b0; flush = 1'b0; ex_memop = MEM_NONE;
    chk("flush.req", {dmemWEN, dmemREN}, 2'd0);
    chk("flush.wbv", wb_valid, 1'b0);
    chk("flush.ready", ex_ready, 1'b1);

    // Stray dhit while idle
    dhit = 1'b1;
    @(posedge CLK); #1;
    dhit = 1'b0;
    chk("stray_dhit.wbv", wb_valid, 1'b0);
    chk("stray_dhit.ready", ex_ready, 1'b1);

    // Snoop to the linked word kills the reservation
    run_instr(MEM_LL, 32'h300, 0, 5'd1, 1, 0, 0, 0, 32'h31, 1'b0, 32'h0, o);
    compare("snp.ll", 2'd1, 32'h300, 0, 0, 32'h31, 5'd1, 1, 0, o);
    snoop_inval = 1'b1; snoop_addr = 32'h302;
    @(posedge CLK); #1;
    snoop_inval = 1'b0;
    run_instr(MEM_SC, 32'h300, 32'h9, 5'd2, 1, 0, 0, 0, 32'h0, 1'b0, 32'h0, o);
    compare("snp.sc", 2'd0, 32'h300, 32'h9, 0, 32'h0, 5'd2, 1, 0, o);

    // Snoop to another word leaves the reservation intact
    run_instr(MEM_LL, 32'h700, 0, 5'd1, 1, 0, 0, 0, 32'h71, 1'b0, 32'h0, o);
    compare("snp_other.ll", 2'd1, 32'h700, 0, 0, 32'h71, 5'd1, 1, 0, o);
    snoop_inval = 1'b1; snoop_addr = 32'h704;
    @(posedge CLK); #1;
    snoop_inval = 1'b0;
    run_instr(MEM_SC, 32'h700, 32'h2, 5'd2, 1, 0, 0, 0, 32'h0, 1'b0, 32'h0, o);
    compare("snp_other.sc", 2'd2, 32'h700, 32'h2, 0, 32'h1, 5'd2, 1, 0, o);

    // Snoop coincident with the LL dhit wins
    run_instr(MEM_LL, 32'h600, 0, 5'd1, 1, 0, 0, 1, 32'h61, 1'b1, 32'h600, o);
    compare("snp_coinc.ll", 2'd1, 32'h600, 0, 1, 32'h61, 5'd1, 1, 0, o);
    run_instr(MEM_SC, 32'h600, 32'h3, 5'd2, 1, 0, 0, 0, 32'h0, 1'b0, 32'h0, o);
    compare("snp_coinc.sc", 2'd0, 32'h600, 32'h3, 0, 32'h0, 5'd2, 1, 0, o);

    // Reset in the middle of an access; the reservation is lost as well
    run_instr(MEM_LL, 32'h800, 0, 5'd1, 1, 0, 0, 0, 32'h81, 1'b0, 32'h0, o);
    compare("rstmid.ll", 2'd1, 32'h800, 0, 0, 32'h81, 5'd1, 1, 0, o);
    ex_valid = 1'b1; ex_memop = MEM_LW; ex_aluout = 32'h500;
    @(posedge CLK); #1;
    ex_valid = 1'b0; ex_memop = MEM_NONE;
    chk("rstmid.ren_before", dmemREN, 1'b1);
    RST = 1'b1;
    #1;
    chk("rstmid.ren_now", dmemREN, 1'b0);
    chk("rstmid.ready_now", ex_ready, 1'b1);
    @(posedge CLK); #1;
    RST = 1'b0; dhit = 1'b1; dmemload = 32'h12345678;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge CLK); #1;
      dhit = 1'b0;
      if (wb_valid) seen = 1'b1;
    end
    chk("rstmid.no_wb", seen, 1'b0);
    chk("rstmid.ren_after", dmemREN, 1'b0);
    run_instr(MEM_SC, 32'h800, 32'h4, 5'd2, 1, 0, 0, 0, 32'h0, 1'b0, 32'h0, o);
    compare("rstmid.sc", 2'd0, 32'h800, 32'h4, 0, 32'h0, 5'd2, 1, 0, o);

    // Randomized run against the reference model
    m_valid = 1'b0; m_addr = '0;
    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        sa = 32'h100 + $urandom_range(0, 15);
        snoop_inval = 1'b1; snoop_addr = sa;
        @(posedge CLK); #1;
        snoop_inval = 1'b0;
        if (m_valid && (sa / 4) == (m_addr / 4)) m_valid = 1'b0;
      end
      op = mem_op_t'($urandom_range(0, 4));
      if (op == MEM_NONE) a = $urandom();
      else begin
        a = 32'h100 + ($urandom_range(0, 3) << 2);
        if ($urandom_range(0, 7) == 0) a = a + $urandom_range(1, 3);
      end
      st = $urandom(); ld = $urandom(); ws = 5'($urandom_range(0, 31));
      rw = 1'($urandom_range(0, 1));
      trap = ($urandom_range(0, 5) == 0); ovf = 1'($urandom_range(0, 1));
      lat = $urandom_range(0, 3);
      model(op, a, rw, trap, ovf, ld, ereq, eres, erw, eexc);
      run_instr(op, a, st, ws, rw, trap, ovf, lat, ld, 1'b0, 32'h0, o);
      compare($sformatf("rnd%0d", n), ereq, a, st, lat, eres, ws, erw, eexc, o);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
